param_seq_detector: RTL and testbench

- Serial bit-stream pattern detector. Parametrised successor to the fixed-pattern Mealy/Moore detectors.
- Pattern length, reset pattern, output style (Mealy/Moore) and overlap mode are compile-time parameters.
- The pattern can be reloaded at runtime. A saturating match counter is included.
- Sits on the serial data path and drives a match flag to downstream control logic.

---
 rtl/param_seq_detector.sv | 120 ++++++++++++
 tb/tb_param_seq_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
// ---------------------------------------------------------------------------
// param_seq_detector
//
// Serial bit-stream pattern detector with a runtime-reloadable pattern,
// selectable Mealy/Moore match flag, selectable overlap behaviour and a
// saturating match counter.
//
// Handshake: din is a valid-only stream (no back-pressure). A bit is accepted
// on a rising clk edge when din_valid=1 and load=0. load takes priority over
// din_valid: on a load edge din is dropped and the pattern is replaced.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  pattern loaded at reset, bit [PAT_LEN-1] is received first
//   MOORE    0: flag is combinational (same cycle as final bit)
//            1: flag is registered (one cycle after the final bit)
//   OVERLAP  1: history kept after a match, 0: history discarded
//   CNT_W    match counter width
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   din        serial data bit
//   din_valid  din qualifier
//   load       pattern load strobe
//   load_pat   new pattern, captured when load=1
//   flag       match indication
//   match_cnt  matches since reset/load, saturating at all-ones
//   cnt_sat    high while match_cnt is all-ones
// ---------------------------------------------------------------------------
module param_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 MOORE   = 1'b0,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               load,
    input  logic [PAT_LEN-1:0] load_pat,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // fill counts 0..PAT_LEN-1, so $clog2(PAT_LEN) bits are enough
    localparam int                FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-2:0] hist;      // newest accepted bit in bit 0
    logic [FILL_W-1:0]  fill;
    logic [CNT_W-1:0]   cnt_q;

    logic [PAT_LEN-1:0] window;    // history plus the bit on din right now
    logic               accept;
    logic               hit;

    assign window = {hist, din};
    assign accept = din_valid & ~load;
    // fill gates out bits that predate a reset or load
    assign hit    = accept & (fill == FILL_FULL) & (window == pat_reg);

    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            pat_reg <= load_pat;
            hist    <= '0;
            fill    <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            if (hit && !OVERLAP) begin
                // non-overlapping: next match needs PAT_LEN fresh bits
                hist <= '0;
                fill <= '0;
            end else begin
                // dropping the MSB of window keeps the newest PAT_LEN-1 bits
                hist <= window[PAT_LEN-2:0];
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
            if (hit && !cnt_sat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    generate
        if (MOORE) begin : g_moore
            logic flag_q;

            // hit is already 0 on load or din_valid=0 edges, so the flag
            // clears on the following edge in those cases
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    flag_q <= 1'b0;
                end else begin
                    flag_q <= hit;
                end
            end

            assign flag = flag_q;
        end else begin : g_mealy
            // reset must hold the combinational flag low even mid-cycle
            assign flag = hit & rst;
        end
    endgenerate

endmodule

// File: tb/tb_param_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_param_seq_detector
//
// Five detector instances with different parameter sets share clk/rst/din.
// din_valid and load are steered to one instance at a time through sel, so
// the idle instances hold their state. Each stimulus step pushes the
// expected {flag, match_cnt, cnt_sat} for the selected instance; a monitor
// on the falling edge pops and compares everything queued.
//
// Sampling point: inputs change 1 ns after a rising edge and outputs are
// sampled at the following falling edge. At that point a Mealy flag reflects
// the bit being presented, a Moore flag reflects the hit of the previous
// edge, and match_cnt reflects all edges before the presented bit.
//
//   u_a : 1011, Mealy, overlap       (id 0)
//   u_b : 1011, Moore, no overlap    (id 1)
//   u_c : 1111, Mealy, overlap       (id 2)
//   u_d : 1111, Mealy, no overlap    (id 3)
//   u_e : 11 (PAT_LEN=2), CNT_W=2    (id 4)
// ---------------------------------------------------------------------------
module tb_param_seq_detector;

  localparam int EXP_W = 8 + 3 + 1 + 8 + 1; // step, id, flag, cnt, sat

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       load;
  logic [3:0] load_pat;
  logic [1:0] load_pat_e;
  int         sel;

  logic       v_a, v_b, v_c, v_d, v_e;
  logic       l_a, l_b, l_c, l_d, l_e;
  logic       flag_a, flag_b, flag_c, flag_d, flag_e;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [1:0] cnt_e;
  logic       sat_a, sat_b, sat_c, sat_d, sat_e;

  logic [EXP_W-1:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  int               step_no;

  assign v_a = din_valid & (sel == 0);
  assign v_b = din_valid & (sel == 1);
  assign v_c = din_valid & (sel == 2);
  assign v_d = din_valid & (sel == 3);
  assign v_e = din_valid & (sel == 4);
  assign l_a = load & (sel == 0);
  assign l_b = load & (sel == 1);
  assign l_c = load & (sel == 2);
  assign l_d = load & (sel == 3);
  assign l_e = load & (sel == 4);

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(v_a), .load(l_a), .load_pat(load_pat),
    .flag(flag_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .MOORE(1'b1), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(v_b), .load(l_b), .load_pat(load_pat),
    .flag(flag_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(v_c), .load(l_c), .load_pat(load_pat),
    .flag(flag_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .MOORE(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u_d (
    .clk(clk), .rst(rst), .din(din), .din_valid(v_d), .load(l_d), .load_pat(load_pat),
    .flag(flag_d), .match_cnt(cnt_d), .cnt_sat(sat_d));

  param_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(2)) u_e (
    .clk(clk), .rst(rst), .din(din), .din_valid(v_e), .load(l_e), .load_pat(load_pat_e),
    .flag(flag_e), .match_cnt(cnt_e), .cnt_sat(sat_e));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int id, input logic ef, input int ec, input logic es);
    exp_q.push_back({8'(step_no), 3'(id), ef, 8'(ec), es});
    step_no++;
  endtask

  // one cycle of stimulus for instance id plus its expected outputs
  task automatic step(input int id, input logic d, input logic v, input logic l,
                      input logic [3:0] lp, input logic ef, input int ec, input logic es);
    @(posedge clk);
    #1;
    sel       = id;
    din       = d;
    din_valid = v;
    load      = l;
    load_pat  = lp;
    push_exp(id, ef, ec, es);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin : pop_one
      logic [EXP_W-1:0] e;
      logic [7:0]       e_step;
      logic [2:0]       e_id;
      logic             e_flag, a_flag;
      logic [7:0]       e_cnt, a_cnt;
      logic             e_sat, a_sat;
      e = exp_q.pop_front();
      {e_step, e_id, e_flag, e_cnt, e_sat} = e;
      case (e_id)
        3'd0:    begin a_flag = flag_a; a_cnt = cnt_a;          a_sat = sat_a; end
        3'd1:    begin a_flag = flag_b; a_cnt = cnt_b;          a_sat = sat_b; end
        3'd2:    begin a_flag = flag_c; a_cnt = cnt_c;          a_sat = sat_c; end
        3'd3:    begin a_flag = flag_d; a_cnt = cnt_d;          a_sat = sat_d; end
        default: begin a_flag = flag_e; a_cnt = {6'd0, cnt_e};  a_sat = sat_e; end
      endcase
      n_checks++;
      if ({a_flag, a_cnt, a_sat} !== {e_flag, e_cnt, e_sat}) begin
        n_errors++;
        $display("FAIL step%0d u%0d flag=%0b exp %0b cnt=%0d exp %0d sat=%0b exp %0b",
                 e_step, e_id, a_flag, e_flag, a_cnt, e_cnt, a_sat, e_sat);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    step_no    = 0;
    rst        = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    load       = 1'b0;
    load_pat   = 4'b0000;
    load_pat_e = 2'b00;
    sel        = 0;

    // reset state of every instance
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push_exp(i, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // u_a 1011 Mealy overlap: 1,0,1,1,0,1,1 -> flag on bits 4 and 7
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 1, 0, 0);
    step(0, 0, 1, 0, 4'h0, 0, 1, 0);
    step(0, 1, 1, 0, 4'h0, 0, 1, 0);
    step(0, 1, 1, 0, 4'h0, 1, 1, 0);
    step(0, 0, 0, 0, 4'h0, 0, 2, 0);

    // u_b 1011 Moore no-overlap: one flag cycle after the bit-4 edge
    step(1, 1, 1, 0, 4'h0, 0, 0, 0);
    step(1, 0, 1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 1, 0, 4'h0, 0, 0, 0);
    step(1, 0, 1, 0, 4'h0, 1, 1, 0);
    step(1, 1, 1, 0, 4'h0, 0, 1, 0);
    step(1, 1, 1, 0, 4'h0, 0, 1, 0);
    step(1, 0, 0, 0, 4'h0, 0, 1, 0);

    // u_c 1111 overlap, six 1s -> 3 matches
    for (int i = 0; i < 3; i++) step(2, 1, 1, 0, 4'h0, 0, 0, 0);
    step(2, 1, 1, 0, 4'h0, 1, 0, 0);
    step(2, 1, 1, 0, 4'h0, 1, 1, 0);
    step(2, 1, 1, 0, 4'h0, 1, 2, 0);
    step(2, 0, 0, 0, 4'h0, 0, 3, 0);

    // u_d 1111 no overlap, six 1s -> 1 match
    for (int i = 0; i < 3; i++) step(3, 1, 1, 0, 4'h0, 0, 0, 0);
    step(3, 1, 1, 0, 4'h0, 1, 0, 0);
    step(3, 1, 1, 0, 4'h0, 0, 1, 0);
    step(3, 1, 1, 0, 4'h0, 0, 1, 0);
    step(3, 0, 0, 0, 4'h0, 0, 1, 0);

    // u_a gaps: 1,0, three invalid cycles, 1,1 -> match on the final 1
    step(0, 1, 1, 0, 4'h0, 0, 2, 0);
    step(0, 0, 1, 0, 4'h0, 0, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'h0, 0, 2, 0);
    step(0, 1, 1, 0, 4'h0, 0, 2, 0);
    step(0, 1, 1, 0, 4'h0, 1, 2, 0);
    // load 0110 alongside a valid bit: bit dropped, counter cleared
    step(0, 1, 1, 1, 4'b0110, 0, 3, 0);
    step(0, 0, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 1, 0, 4'h0, 1, 0, 0);

    // u_e PAT_LEN=2 pattern 11, CNT_W=2: counter saturates at 3
    step(4, 1, 1, 0, 4'h0, 0, 0, 0);
    step(4, 1, 1, 0, 4'h0, 1, 0, 0);
    step(4, 1, 1, 0, 4'h0, 1, 1, 0);
    step(4, 1, 1, 0, 4'h0, 1, 2, 0);
    step(4, 1, 1, 0, 4'h0, 1, 3, 1);
    step(4, 0, 0, 0, 4'h0, 0, 3, 1);

    // u_a reload 1011, get one match, then 1,0,1 and async reset mid-cycle
    step(0, 0, 1, 1, 4'b1011, 0, 1, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 1, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 1, 0);
    step(0, 0, 1, 0, 4'h0, 0, 1, 0);
    step(0, 1, 1, 0, 4'h0, 0, 1, 0);
    // din=1 here would complete 1011; reset drops between the edges
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    rst       = 1'b1;
    // after release: 1,1,0,1,1 -> single match on the 5th bit
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 0, 4'h0, 1, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 1, 0);

    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain queue_left=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
